// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl
// Command-driven sequencer for an external bank of WIDTH JK flip-flops.
// It turns single commands (LOAD, SET, CLEAR, TOGGLE, SHL, SHR) into the
// per-cell J/K patterns and reads the bank back through q_i.
//
// Ports:
//   clk        system clock, shared with the bank cells
//   rst        synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (IDLE only)
//   cmd_op     opcode: 0 NOP, 1 LOAD, 2 SET, 3 CLEAR, 4 TOGGLE, 5 SHL, 6 SHR, 7 NOP
//   cmd_data   LOAD value / SET-CLEAR-TOGGLE mask / shift serial-in on bit 0
//   cmd_cnt    shift count (SHL/SHR only)
//   j_o, k_o   J and K inputs of the bank
//   q_i        Q outputs of the bank
//   done       one-cycle pulse when a command has completed
//   err        sticky readback error
//
// Optional feature macro: JKC_READBACK_CHECK_EN
//   When defined, a shadow of the expected bank value is kept and compared
//   with q_i when a command completes; a mismatch sets err until reset.
//   When undefined, err is tied to 0.

module jk_bank_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CW-1:0]    cmd_cnt,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    input  logic [WIDTH-1:0] q_i,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_SHL    = 3'd5;
    localparam logic [2:0] OP_SHR    = 3'd6;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             is_shift;
    logic             shift_active;
    logic             last_exec;
    logic [WIDTH-1:0] shl_src;
    logic [WIDTH-1:0] shr_src;

    // Ready is also gated by rst so a command held during reset is never taken.
    assign cmd_ready = (state == IDLE) && rst;
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == RESP);

    assign is_shift     = (op_q == OP_SHL) || (op_q == OP_SHR);
    // A zero-count shift still spends one EXEC cycle, but with the bank holding.
    assign shift_active = is_shift && (cnt_q != '0);
    // The counter still holds the cycles remaining including the current one.
    assign last_exec    = !is_shift || (cnt_q <= CW'(1));

    // Next value of each cell when shifting, taken from its neighbour in the bank.
    assign shl_src = {q_i[WIDTH-2:0], data_q[0]};
    assign shr_src = {data_q[0], q_i[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt_q <= ((cmd_op == OP_SHL) || (cmd_op == OP_SHR)) ? cmd_cnt : '0;
            end else if ((state == EXEC) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // The command fields need no reset: they are only looked at in EXEC/RESP,
    // which is reachable only through an accept that loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)    state_nxt = EXEC;
            EXEC: if (last_exec) state_nxt = RESP;
            RESP:                state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // J/K decode depends only on state, latched command and q_i.
    always_comb begin
        j_o = '0;
        k_o = '0;
        if (state == EXEC) begin
            case (op_q)
                OP_LOAD: begin
                    j_o = data_q;
                    k_o = ~data_q;
                end
                OP_SET: begin
                    j_o = data_q;
                end
                OP_CLEAR: begin
                    k_o = data_q;
                end
                OP_TOGGLE: begin
                    j_o = data_q;
                    k_o = data_q;
                end
                OP_SHL: begin
                    if (shift_active) begin
                        j_o = shl_src;
                        k_o = ~shl_src;
                    end
                end
                OP_SHR: begin
                    if (shift_active) begin
                        j_o = shr_src;
                        k_o = ~shr_src;
                    end
                end
                default: begin
                    j_o = '0;
                    k_o = '0;
                end
            endcase
        end
    end

`ifdef JKC_READBACK_CHECK_EN
    logic [WIDTH-1:0] shadow;
    logic             err_q;
    logic             mismatch;

    assign mismatch = (state == RESP) && (shadow != q_i);
    // The combinational term makes err visible already in the RESP cycle.
    assign err      = err_q | mismatch;

    // Shadow starts from the bank value at acceptance; shifts are then applied
    // one step per active EXEC cycle, exactly as the bank sees them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                case (cmd_op)
                    OP_LOAD:   shadow <= cmd_data;
                    OP_SET:    shadow <= q_i | cmd_data;
                    OP_CLEAR:  shadow <= q_i & ~cmd_data;
                    OP_TOGGLE: shadow <= q_i ^ cmd_data;
                    default:   shadow <= q_i;
                endcase
            end else if ((state == EXEC) && shift_active) begin
                if (op_q == OP_SHL) begin
                    shadow <= {shadow[WIDTH-2:0], data_q[0]};
                end else begin
                    shadow <= {data_q[0], shadow[WIDTH-1:1]};
                end
            end
            if (mismatch) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl
// Directed bench for jk_bank_ctrl with WIDTH=8, CW=4. A behavioural JK bank
// is modelled here and driven by j_o/k_o; its Q is fed back through q_i,
// optionally with a stuck-at-0 read path for the readback-error scenario.

module tb_jk_bank_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CW-1:0]    cmd_cnt;
    logic [WIDTH-1:0] j_o;
    logic [WIDTH-1:0] k_o;
    logic [WIDTH-1:0] q_i;
    logic             done;
    logic             err;

    logic [WIDTH-1:0] bank  = '0;
    logic [WIDTH-1:0] stuck = '0;

    int checks = 0;
    int passed = 0;

    jk_bank_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .j_o       (j_o),
        .k_o       (k_o),
        .q_i       (q_i),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // JK bank model: 10 set, 01 clear, 11 toggle, 00 hold.
    always @(posedge clk) begin
        if (!$isunknown({j_o, k_o})) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j_o[i], k_o[i]})
                    2'b10:   bank[i] <= 1'b1;
                    2'b01:   bank[i] <= 1'b0;
                    2'b11:   bank[i] <= ~bank[i];
                    default: bank[i] <= bank[i];
                endcase
            end
        end
    end

    assign q_i = bank & ~stuck;

    // Issues one command and follows it to done (bounded). Reports the EXEC
    // cycle count, J/K of the first EXEC cycle, and the state at done.
    task automatic run_cmd(
        input  logic [2:0]       op,
        input  logic [WIDTH-1:0] data,
        input  logic [CW-1:0]    cnt,
        output int               n_exec,
        output logic [WIDTH-1:0] j_first,
        output logic [WIDTH-1:0] k_first,
        output logic             got_done,
        output logic [WIDTH-1:0] q_done,
        output logic             err_done,
        output logic             ready_done,
        output logic             idle_bad
    );
        n_exec     = 0;
        j_first    = '0;
        k_first    = '0;
        got_done   = 1'b0;
        q_done     = '0;
        err_done   = 1'b0;
        ready_done = 1'b0;
        idle_bad   = 1'b0;
        @(negedge clk);
        if (!cmd_ready || (j_o !== '0) || (k_o !== '0)) idle_bad = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        cmd_cnt   = '0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge clk);
            if (done) begin
                got_done   = 1'b1;
                q_done     = q_i;
                err_done   = err;
                ready_done = cmd_ready;
                if ((j_o !== '0) || (k_o !== '0)) idle_bad = 1'b1;
            end else if (!cmd_ready) begin
                if (n_exec == 0) begin
                    j_first = j_o;
                    k_first = k_o;
                end
                n_exec++;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 8'hFF;
        cmd_cnt   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if ({j_o, k_o} !== 16'h0) $display("[TB] FAIL reset_jk: got %h expected 0000", {j_o, k_o}); else passed++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passed++;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); else passed++;
        checks++; if (q_i !== 8'h00) $display("[TB] FAIL reset_no_accept: got %h expected 00", q_i); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_no_done: got %b expected 0", done); else passed++;
    endtask

    task automatic test_load();
        int n; logic [7:0] jf, kf, qd; logic gd, ed, rd, ib;
        run_cmd(3'd1, 8'hA5, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (gd !== 1'b1) $display("[TB] FAIL load_done: got %b expected 1", gd); else passed++;
        checks++; if (n !== 1) $display("[TB] FAIL load_exec_len: got %0d expected 1", n); else passed++;
        checks++; if (jf !== 8'hA5) $display("[TB] FAIL load_j: got %h expected a5", jf); else passed++;
        checks++; if (kf !== 8'h5A) $display("[TB] FAIL load_k: got %h expected 5a", kf); else passed++;
        checks++; if (qd !== 8'hA5) $display("[TB] FAIL load_q: got %h expected a5", qd); else passed++;
        checks++; if (ed !== 1'b0) $display("[TB] FAIL load_err: got %b expected 0", ed); else passed++;
        checks++; if (rd !== 1'b0) $display("[TB] FAIL load_ready_resp: got %b expected 0", rd); else passed++;
        checks++; if (ib !== 1'b0) $display("[TB] FAIL load_idle_jk: got %b expected 0", ib); else passed++;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL load_ready_after: got %b expected 1", cmd_ready); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL load_done_pulse: got %b expected 0", done); else passed++;
    endtask

    task automatic test_set_clear_toggle();
        int n; logic [7:0] jf, kf, qd; logic gd, ed, rd, ib;
        run_cmd(3'd2, 8'h0F, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (qd !== 8'hAF) $display("[TB] FAIL set_q: got %h expected af", qd); else passed++;
        checks++; if ({jf, kf} !== 16'h0F00) $display("[TB] FAIL set_jk: got %h expected 0f00", {jf, kf}); else passed++;
        checks++; if (ib !== 1'b0) $display("[TB] FAIL set_idle_jk: got %b expected 0", ib); else passed++;
        run_cmd(3'd3, 8'h80, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (qd !== 8'h2F) $display("[TB] FAIL clear_q: got %h expected 2f", qd); else passed++;
        checks++; if ({jf, kf} !== 16'h0080) $display("[TB] FAIL clear_jk: got %h expected 0080", {jf, kf}); else passed++;
        checks++; if (ib !== 1'b0) $display("[TB] FAIL clear_idle_jk: got %b expected 0", ib); else passed++;
        run_cmd(3'd4, 8'hFF, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (qd !== 8'hD0) $display("[TB] FAIL toggle_q: got %h expected d0", qd); else passed++;
        checks++; if ({jf, kf} !== 16'hFFFF) $display("[TB] FAIL toggle_jk: got %h expected ffff", {jf, kf}); else passed++;
        checks++; if (n !== 1) $display("[TB] FAIL toggle_exec_len: got %0d expected 1", n); else passed++;
        checks++; if (ib !== 1'b0) $display("[TB] FAIL toggle_idle_jk: got %b expected 0", ib); else passed++;
    endtask

    task automatic test_shift();
        int n; logic [7:0] jf, kf, qd; logic gd, ed, rd, ib;
        run_cmd(3'd1, 8'h81, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (qd !== 8'h81) $display("[TB] FAIL shift_preload: got %h expected 81", qd); else passed++;
        run_cmd(3'd5, 8'h01, 4'd3, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (n !== 3) $display("[TB] FAIL shl_exec_len: got %0d expected 3", n); else passed++;
        checks++; if (qd !== 8'h0F) $display("[TB] FAIL shl_q: got %h expected 0f", qd); else passed++;
        checks++; if ({jf, kf} !== 16'h03FC) $display("[TB] FAIL shl_jk: got %h expected 03fc", {jf, kf}); else passed++;
        run_cmd(3'd6, 8'h00, 4'd2, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (n !== 2) $display("[TB] FAIL shr_exec_len: got %0d expected 2", n); else passed++;
        checks++; if (qd !== 8'h03) $display("[TB] FAIL shr_q: got %h expected 03", qd); else passed++;
        checks++; if ({jf, kf} !== 16'h07F8) $display("[TB] FAIL shr_jk: got %h expected 07f8", {jf, kf}); else passed++;
        checks++; if (ed !== 1'b0) $display("[TB] FAIL shr_err: got %b expected 0", ed); else passed++;
    endtask

    task automatic test_zero_count_nop();
        int n; logic [7:0] jf, kf, qd; logic gd, ed, rd, ib;
        run_cmd(3'd5, 8'h01, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (n !== 1) $display("[TB] FAIL shl0_exec_len: got %0d expected 1", n); else passed++;
        checks++; if ({jf, kf} !== 16'h0000) $display("[TB] FAIL shl0_jk: got %h expected 0000", {jf, kf}); else passed++;
        checks++; if (qd !== 8'h03) $display("[TB] FAIL shl0_q: got %h expected 03", qd); else passed++;
        checks++; if (gd !== 1'b1) $display("[TB] FAIL shl0_done: got %b expected 1", gd); else passed++;
        run_cmd(3'd7, 8'hFF, 4'd5, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (n !== 1) $display("[TB] FAIL op7_exec_len: got %0d expected 1", n); else passed++;
        checks++; if ({jf, kf} !== 16'h0000) $display("[TB] FAIL op7_jk: got %h expected 0000", {jf, kf}); else passed++;
        checks++; if (qd !== 8'h03) $display("[TB] FAIL op7_q: got %h expected 03", qd); else passed++;
        run_cmd(3'd0, 8'hFF, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (qd !== 8'h03) $display("[TB] FAIL nop_q: got %h expected 03", qd); else passed++;
    endtask

    task automatic test_reset_mid_exec();
        int n;
        logic saw_done;
        n        = 0;
        saw_done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_data  = 8'h01;
        cmd_cnt   = 4'd10;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        cmd_cnt   = '0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (!cmd_ready && !done) n++;
        end
        checks++; if (n !== 4) $display("[TB] FAIL abort_reach_exec4: got %0d expected 4", n); else passed++;
        checks++; if (q_i !== 8'h1F) $display("[TB] FAIL abort_q_exec4: got %h expected 1f", q_i); else passed++;
        checks++; if (j_o !== 8'h3F) $display("[TB] FAIL abort_j_exec4: got %h expected 3f", j_o); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({j_o, k_o} !== 16'h0000) $display("[TB] FAIL abort_jk: got %h expected 0000", {j_o, k_o}); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL abort_done: got %b expected 0", done); else passed++;
        checks++; if (q_i !== 8'h3F) $display("[TB] FAIL abort_q: got %h expected 3f", q_i); else passed++;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL abort_ready: got %b expected 1", cmd_ready); else passed++;
        checks++; if (saw_done !== 1'b0) $display("[TB] FAIL abort_no_done: got %b expected 0", saw_done); else passed++;
        checks++; if (q_i !== 8'h3F) $display("[TB] FAIL abort_bank_hold: got %h expected 3f", q_i); else passed++;
    endtask

    task automatic test_readback();
        int n; logic [7:0] jf, kf, qd; logic gd, ed, rd, ib;
        stuck = 8'h08;
        run_cmd(3'd1, 8'hFF, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (qd !== 8'hF7) $display("[TB] FAIL rb_q: got %h expected f7", qd); else passed++;
`ifdef JKC_READBACK_CHECK_EN
        checks++; if (ed !== 1'b1) $display("[TB] FAIL rb_err_set: got %b expected 1", ed); else passed++;
`else
        checks++; if (ed !== 1'b0) $display("[TB] FAIL rb_err_tied: got %b expected 0", ed); else passed++;
`endif
        stuck = 8'h00;
        run_cmd(3'd1, 8'h00, 4'd0, n, jf, kf, gd, qd, ed, rd, ib);
        checks++; if (qd !== 8'h00) $display("[TB] FAIL rb_q2: got %h expected 00", qd); else passed++;
`ifdef JKC_READBACK_CHECK_EN
        checks++; if (ed !== 1'b1) $display("[TB] FAIL rb_err_sticky: got %b expected 1", ed); else passed++;
`else
        checks++; if (ed !== 1'b0) $display("[TB] FAIL rb_err_tied2: got %b expected 0", ed); else passed++;
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if (err !== 1'b0) $display("[TB] FAIL rb_err_reset: got %b expected 0", err); else passed++;
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        cmd_cnt   = '0;
        test_reset();
        test_load();
        test_set_clear_toggle();
        test_shift();
        test_zero_count_nop();
        test_reset_mid_exec();
        test_readback();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
